// File: rtl/imem_arbiter_pkg.sv
// Shared parameters for the instruction-memory arbiter and the CPU core:
// grant-state encoding, requester IDs and opcode constants.
package imem_arbiter_pkg;

   typedef enum logic {
      ARB_RR     = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_DBG   = 1'b1
   } requester_e;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_JMP  = 4'h4,
      OP_BRZ  = 4'h5,
      OP_HALT = 4'hF
   } cpu_opcode_e;

   localparam int STARVE_W = 3;

   function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
      if (v == {STARVE_W{1'b1}}) begin
         return v;
      end else begin
         return v + 3'd1;
      end
   endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates one single-port program memory between CPU fetch and a debug/loader
// port: round-robin normally, debug-priority with anti-starvation while locked.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int PC_WIDTH          = 8,
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int STARVE_LIMIT      = 4
) (
   input  logic                         clock,
   input  logic                         isReset,
   input  logic                         fetchReq,
   input  logic [PC_WIDTH-1:0]          fetchAddr,
   output logic                         fetchGrant,
   output logic                         fetchValid,
   output logic [INSTRUCTION_WIDTH-1:0] fetchData,
   input  logic                         dbgReq,
   input  logic                         dbgWrite,
   input  logic                         dbgLock,
   input  logic [PC_WIDTH-1:0]          dbgAddr,
   input  logic [INSTRUCTION_WIDTH-1:0] dbgWData,
   output logic                         dbgGrant,
   output logic                         dbgValid,
   output logic [INSTRUCTION_WIDTH-1:0] dbgRData,
   output logic                         memEn,
   output logic                         memWe,
   output logic [PC_WIDTH-1:0]          memAddr,
   output logic [INSTRUCTION_WIDTH-1:0] memWData,
   input  logic [INSTRUCTION_WIDTH-1:0] memRData
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);

   arb_state_e            r_state;
   requester_e            r_last;
   logic [STARVE_W-1:0]   r_starve;
   logic                  r_fetch_pend;
   logic                  r_dbg_pend;

   logic                  w_fetch_win;
   logic                  w_dbg_win;
   arb_state_e            w_state_nxt;
   logic [STARVE_W-1:0]   w_starve_nxt;

   // Winner selection for the current cycle.
   always_comb begin
      w_fetch_win = 1'b0;
      w_dbg_win   = 1'b0;
      if (isReset) begin
         w_fetch_win = 1'b0;
         w_dbg_win   = 1'b0;
      end else begin
         case (r_state)
            ARB_LOCKED: begin
               if (fetchReq && (r_starve == STARVE_LIM)) begin
                  w_fetch_win = 1'b1;
               end else if (dbgReq) begin
                  w_dbg_win = 1'b1;
               end else begin
                  w_fetch_win = fetchReq;
               end
            end
            ARB_RR: begin
               if (fetchReq && dbgReq) begin
                  w_fetch_win = (r_last == REQ_DBG);
                  w_dbg_win   = (r_last == REQ_FETCH);
               end else begin
                  w_fetch_win = fetchReq;
                  w_dbg_win   = dbgReq;
               end
            end
            default: begin
               w_fetch_win = 1'b0;
               w_dbg_win   = 1'b0;
            end
         endcase
      end
   end

   // Next lock state and starve count; the grant that opens a lock already counts.
   always_comb begin
      w_state_nxt  = ARB_RR;
      w_starve_nxt = 3'd0;
      case (r_state)
         ARB_RR:     w_state_nxt = (w_dbg_win && dbgLock) ? ARB_LOCKED : ARB_RR;
         ARB_LOCKED: w_state_nxt = dbgLock ? ARB_LOCKED : ARB_RR;
         default:    w_state_nxt = ARB_RR;
      endcase
      if (w_state_nxt != ARB_LOCKED) begin
         w_starve_nxt = 3'd0;
      end else if (w_fetch_win || !fetchReq) begin
         w_starve_nxt = 3'd0;
      end else if (w_dbg_win) begin
         w_starve_nxt = starve_inc(r_starve);
      end else begin
         w_starve_nxt = r_starve;
      end
   end

   // Arbiter state and read-return tracking.
   always_ff @(posedge clock) begin
      if (isReset) begin
         r_state      <= ARB_RR;
         r_last       <= REQ_DBG;
         r_starve     <= 3'd0;
         r_fetch_pend <= 1'b0;
         r_dbg_pend   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve     <= w_starve_nxt;
         r_fetch_pend <= w_fetch_win;
         r_dbg_pend   <= w_dbg_win && !dbgWrite;
         if (w_fetch_win) begin
            r_last <= REQ_FETCH;
         end else if (w_dbg_win) begin
            r_last <= REQ_DBG;
         end else begin
            r_last <= r_last;
         end
      end
   end

   assign fetchGrant = w_fetch_win;
   assign dbgGrant   = w_dbg_win;
   assign memEn      = w_fetch_win | w_dbg_win;
   assign memWe      = w_dbg_win & dbgWrite;
   assign memAddr    = w_dbg_win ? dbgAddr : fetchAddr;
   assign memWData   = w_dbg_win ? dbgWData : {INSTRUCTION_WIDTH{1'b0}};

   // Gating with isReset keeps a read return from leaking out during the reset cycle.
   assign fetchValid = r_fetch_pend & ~isReset;
   assign dbgValid   = r_dbg_pend & ~isReset;
   assign fetchData  = memRData;
   assign dbgRData   = memRData;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vectors with literal expectations plus a
// rule-level model checked every cycle.
module tb_imem_arbiter;

   localparam int PW = 8;
   localparam int IW = 16;
   localparam int SL = 4;

   logic          clock = 1'b0;
   logic          isReset;
   logic          fetchReq;
   logic [PW-1:0] fetchAddr;
   logic          fetchGrant;
   logic          fetchValid;
   logic [IW-1:0] fetchData;
   logic          dbgReq;
   logic          dbgWrite;
   logic          dbgLock;
   logic [PW-1:0] dbgAddr;
   logic [IW-1:0] dbgWData;
   logic          dbgGrant;
   logic          dbgValid;
   logic [IW-1:0] dbgRData;
   logic          memEn;
   logic          memWe;
   logic [PW-1:0] memAddr;
   logic [IW-1:0] memWData;
   logic [IW-1:0] memRData = 16'h0000;

   always #5 clock = ~clock;

   imem_arbiter #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .STARVE_LIMIT(SL)) dut (
      .clock(clock), .isReset(isReset),
      .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
      .fetchValid(fetchValid), .fetchData(fetchData),
      .dbgReq(dbgReq), .dbgWrite(dbgWrite), .dbgLock(dbgLock), .dbgAddr(dbgAddr),
      .dbgWData(dbgWData), .dbgGrant(dbgGrant), .dbgValid(dbgValid), .dbgRData(dbgRData),
      .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit run    = 1'b0;

   // Initial memory image: address 3 holds 0x1234, others {a, ~a}.
   function automatic logic [IW-1:0] init_val(input logic [PW-1:0] a);
      if (a == 8'h03) return 16'h1234;
      return {a, ~a};
   endfunction

   logic [IW-1:0] mem     [0:255];
   bit            mem_wr  [0:255];
   logic [IW-1:0] ref_mem [0:255];
   bit            ref_wr  [0:255];

   function automatic logic [IW-1:0] mem_rd(input logic [PW-1:0] a);
      return mem_wr[a] ? mem[a] : init_val(a);
   endfunction

   function automatic logic [IW-1:0] ref_rd(input logic [PW-1:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   // Single-port memory behind the arbiter: one-cycle read latency.
   always @(posedge clock) begin
      if (memEn) begin
         if (memWe) begin
            mem[memAddr]    <= memWData;
            mem_wr[memAddr] <= 1'b1;
         end
         memRData <= mem_rd(memAddr);
      end
   end

   // Reference model state: lock flag, who won last, debug grants while fetch waits.
   bit            m_locked   = 1'b0;
   bit            m_last_dbg = 1'b1;
   int            m_starve   = 0;
   bit            m_fv       = 1'b0;
   bit            m_dv       = 1'b0;
   logic [IW-1:0] m_fd       = 16'h0000;
   logic [IW-1:0] m_dd       = 16'h0000;

   function automatic logic [1:0] model_grant();
      if (isReset) return 2'b00;
      if (m_locked) begin
         if (fetchReq && m_starve == SL) return 2'b10;
         if (dbgReq) return 2'b01;
         return fetchReq ? 2'b10 : 2'b00;
      end
      if (fetchReq && dbgReq) return m_last_dbg ? 2'b10 : 2'b01;
      return {fetchReq, dbgReq};
   endfunction

   logic [1:0] w_eg;
   logic       w_lock_nxt;
   always_comb w_eg = model_grant();
   always_comb w_lock_nxt = m_locked ? dbgLock : (w_eg[0] && dbgLock);

   // Model update at each rising edge.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (isReset) begin
         m_locked   <= 1'b0;
         m_last_dbg <= 1'b1;
         m_starve   <= 0;
         m_fv       <= 1'b0;
         m_dv       <= 1'b0;
      end else begin
         m_fv <= w_eg[1];
         m_fd <= ref_rd(fetchAddr);
         m_dv <= w_eg[0] && !dbgWrite;
         m_dd <= ref_rd(dbgAddr);
         if (w_eg[0] && dbgWrite) begin
            ref_mem[dbgAddr] <= dbgWData;
            ref_wr[dbgAddr]  <= 1'b1;
         end
         if (w_eg != 2'b00) m_last_dbg <= w_eg[0];
         m_locked <= w_lock_nxt;
         if (!w_lock_nxt || w_eg[1] || !fetchReq) m_starve <= 0;
         else if (w_eg[0]) m_starve <= (m_starve < 7) ? m_starve + 1 : 7;
      end
   end

   // Literal expectations for the current directed vector.
   bit            pin_en = 1'b0;
   bit            pin_fg, pin_dg, pin_fv, pin_dv;
   logic [IW-1:0] pin_fd, pin_dd;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Compare process: mid-cycle, against the model and any pinned literals.
   always @(negedge clock) begin
      if (run) begin
         check("fetchGrant", {31'd0, fetchGrant}, {31'd0, w_eg[1]});
         check("dbgGrant", {31'd0, dbgGrant}, {31'd0, w_eg[0]});
         check("memEn", {31'd0, memEn}, {31'd0, (w_eg != 2'b00)});
         check("memWe", {31'd0, memWe}, {31'd0, (w_eg[0] && dbgWrite)});
         if (w_eg != 2'b00)
            check("memAddr", {24'd0, memAddr}, {24'd0, (w_eg[0] ? dbgAddr : fetchAddr)});
         if (w_eg[0] && dbgWrite)
            check("memWData", {16'd0, memWData}, {16'd0, dbgWData});
         check("fetchValid", {31'd0, fetchValid}, {31'd0, (m_fv && !isReset)});
         if (m_fv && !isReset) check("fetchData", {16'd0, fetchData}, {16'd0, m_fd});
         check("dbgValid", {31'd0, dbgValid}, {31'd0, (m_dv && !isReset)});
         if (m_dv && !isReset) check("dbgRData", {16'd0, dbgRData}, {16'd0, m_dd});
         if (pin_en) begin
            check("pin_fetchGrant", {31'd0, fetchGrant}, {31'd0, pin_fg});
            check("pin_dbgGrant", {31'd0, dbgGrant}, {31'd0, pin_dg});
            check("pin_fetchValid", {31'd0, fetchValid}, {31'd0, pin_fv});
            check("pin_dbgValid", {31'd0, dbgValid}, {31'd0, pin_dv});
            if (pin_fv) check("pin_fetchData", {16'd0, fetchData}, {16'd0, pin_fd});
            if (pin_dv) check("pin_dbgRData", {16'd0, dbgRData}, {16'd0, pin_dd});
         end
      end
   end

   task automatic vec(input logic rst, input logic fr, input logic [7:0] fa,
                      input logic dr, input logic dw, input logic dl,
                      input logic [7:0] da, input logic [15:0] wd,
                      input bit en, input bit efg, input bit edg, input bit efv,
                      input logic [15:0] efd, input bit edv, input logic [15:0] edd);
      isReset   = rst;
      fetchReq  = fr;
      fetchAddr = fa;
      dbgReq    = dr;
      dbgWrite  = dw;
      dbgLock   = dl;
      dbgAddr   = da;
      dbgWData  = wd;
      pin_en    = en;
      pin_fg    = efg;
      pin_dg    = edg;
      pin_fv    = efv;
      pin_fd    = efd;
      pin_dv    = edv;
      pin_dd    = edd;
      @(posedge clock);
      #1;
   endtask

   initial begin
      isReset = 1'b1; fetchReq = 1'b0; fetchAddr = 8'h00; dbgReq = 1'b0;
      dbgWrite = 1'b0; dbgLock = 1'b0; dbgAddr = 8'h00; dbgWData = 16'h0000;
      @(posedge clock);
      #1;
      run = 1'b1;
      // Reset, then a single fetch of address 3.
      vec(1, 1, 8'h03, 1, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h03, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h03, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 1, 16'h1234, 0, 16'h0000);
      // Contention without lock: F,D,F,D.
      vec(1, 1, 8'h04, 1, 0, 0, 8'h05, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h04, 1, 0, 0, 8'h05, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h04, 1, 0, 0, 8'h05, 16'h0000, 1, 0, 1, 1, 16'h04FB, 0, 16'h0000);
      vec(0, 1, 8'h04, 1, 0, 0, 8'h05, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 16'h05FA);
      vec(0, 1, 8'h04, 1, 0, 0, 8'h05, 16'h0000, 1, 0, 1, 1, 16'h04FB, 0, 16'h0000);
      vec(0, 0, 8'h04, 0, 0, 0, 8'h05, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 16'h05FA);
      // Debug write then read-back of 0x10.
      vec(0, 0, 8'h00, 1, 1, 0, 8'h10, 16'hBEEF, 1, 0, 1, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h00, 1, 0, 0, 8'h10, 16'hBEEF, 1, 0, 1, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h00, 0, 0, 0, 8'h10, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 16'hBEEF);
      // Locked write burst with fetch held: D,D,D,D,F repeating.
      vec(0, 1, 8'h06, 1, 1, 1, 8'h20, 16'hC0DE, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h06, 1, 1, 1, 8'h20, 16'hC0DE, 1, 0, 1, 1, 16'h06F9, 0, 16'h0000);
      for (int i = 0; i < 3; i++)
         vec(0, 1, 8'h06, 1, 1, 1, 8'h20, 16'hC0DE, 1, 0, 1, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h06, 1, 1, 1, 8'h20, 16'hC0DE, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h06, 1, 1, 1, 8'h21, 16'hC0DF, 1, 0, 1, 1, 16'h06F9, 0, 16'h0000);
      for (int i = 0; i < 3; i++)
         vec(0, 1, 8'h06, 1, 1, 1, 8'h21, 16'hC0DF, 1, 0, 1, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h06, 1, 1, 1, 8'h21, 16'hC0DF, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      // Lock dropped with fetch pending: back to RR, fetch wins next.
      vec(0, 1, 8'h06, 1, 1, 0, 8'h22, 16'hC0E0, 1, 0, 1, 1, 16'h06F9, 0, 16'h0000);
      vec(0, 1, 8'h06, 1, 1, 0, 8'h22, 16'hC0E0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h06, 0, 0, 0, 8'h22, 16'h0000, 1, 0, 0, 1, 16'h06F9, 0, 16'h0000);
      // Reset right after a fetch grant: return discarded, fetch wins after.
      vec(0, 1, 8'h03, 0, 0, 0, 8'h05, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(1, 1, 8'h03, 1, 0, 0, 8'h05, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 1, 8'h03, 1, 0, 0, 8'h05, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h03, 0, 0, 0, 8'h05, 16'h0000, 1, 0, 0, 1, 16'h1234, 0, 16'h0000);
      // Mixed traffic checked against the model only.
      for (int i = 0; i < 200; i++)
         vec(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             8'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)),
             0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vec(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
